mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single PSRAM memory port between the CPU/cache path (port 0) and a secondary master (port 1), such as the serial loader or a future DMA engine.
It grants one whole transaction at a time, single-word or burst, and muxes address, data and control to memory.
It routes ready back only to the granted requester.
It sits between the masters and the memory controller, in the position a direct CPU-to-memory connection otherwise occupies.

Parameters:
AW, 32, address width of both requesters and memory port
DW, 32, data width
BLW, 8, burst length field width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
burst_en_0  in  1  port 0 burst request
burst_length_0  in  BLW  port 0 beat count
a_0  in  AW  port 0 address
d_0  in  DW  port 0 write data
we_0  in  1  port 0 write request (level)
rd_0  in  1  port 0 read request (level)
spo_0  out  DW  read data to port 0
ready_0  out  1  per-beat completion to port 0
burst_en_1, burst_length_1, a_1, d_1, we_1, rd_1, spo_1, ready_1: same as port 0, for port 1
burst_en_mem  out  1  to memory
burst_length_mem  out  BLW  to memory
a_mem  out  AW  to memory
d_mem  out  DW  to memory
we_mem  out  1  to memory
rd_mem  out  1  to memory
spo_mem  in  DW  read data from memory
ready_mem  in  1  per-beat completion pulse from memory
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  grant != 00

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous, active-high.
- Reset values: grant=00, busy=0, beat counter=0, RR pointer=0. With no grant, we_mem=rd_mem=burst_en_mem=0 and ready_0=ready_1=0.
- Request protocol:
  - A port requests by holding we_x or rd_x high until its final ready_x pulse.
  - Requesting both we_x and rd_x at once is illegal; the arbiter passes both through unchanged.
- State machine: IDLE, OWN0, OWN1, RELEASE.
- IDLE:
  - Sample req_x = we_x | rd_x.
  - If only one port requests, go to OWNx at the next edge.
  - If both request, port 0 wins (fixed priority).
  - Latency from request to memory seeing it is 1 cycle.
- OWNx:
  - Mem outputs are combinationally muxed from port x.
  - ready_x = ready_mem; the other port's ready = 0.
  - spo_0 = spo_1 = spo_mem at all times; data is valid only with the owner's ready.
- Beat counting:
  - Non-burst (burst_en_x=0 at grant): the transaction ends on the first ready_mem pulse.
  - Burst: beats = burst_length_x, where 0 counts as 1. The counter is BLW bits, counts ready_mem pulses, and the transaction ends when count == beats.
  - burst_length_x and burst_en_x are latched at grant; later changes are ignored.
- RELEASE:
  - Lasts exactly 1 cycle with all mem controls deasserted, so the owner can drop its request. Then go to IDLE.
  - Back-to-back transactions from the same port therefore have a 2-cycle gap minimum.
- Request withdrawn mid-transaction: this is illegal. The arbiter keeps the grant until the completion count is reached, and the mem request lines follow port x combinationally.
- ready_mem while IDLE or RELEASE: ignored, not forwarded.
- Simultaneous completion and a new request: the new request is evaluated only in IDLE, after RELEASE.
- Reset mid-transaction: return to IDLE next edge, drop all mem controls, clear the counter. The memory controller is reset by the same rst.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin arbitration. A 1-bit pointer names the last granted port. On a simultaneous request in IDLE, the port other than the pointer wins. The pointer updates on each grant and resets to 0 (so port 1 wins the first contention).
- Undefined: fixed priority, port 0 always wins contention; no pointer register exists.

Test Plan:
- Port 0 single read at 0x100, memory returns 0xDEADBEEF after 3 cycles -> grant=01 one cycle after rd_0, a_mem=0x100, ready_0 pulses with spo_0=0xDEADBEEF, ready_1 stays 0, RELEASE then grant=00.
- rd_0 and we_1 raised the same cycle (d_1=0x12345678) without the macro -> port 0 served first; port 1 granted after RELEASE+IDLE, we_mem=1, d_mem=0x12345678.
- Port 1 burst read, burst_length_1=4, with port 0 requesting during the burst -> 4 ready_1 pulses, no ready_0, grant held until 4th beat; port 0 granted afterwards.
- burst_en_0=1, burst_length_0=0 -> completes after 1 beat.
- rst asserted during OWN1 mid-burst (beat 2 of 4) -> next cycle grant=00, we_mem=rd_mem=0; a new rd_0 afterwards is served normally.
- With MEM_ARB_RR_EN, both ports requesting continuously, 4 transactions -> grant order 1,0,1,0; without the macro -> 0,0,0,0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one PSRAM port; grants a whole (burst) transaction at a time.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BLW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           burst_en_0,
    input  logic [BLW-1:0] burst_length_0,
    input  logic [AW-1:0]  a_0,
    input  logic [DW-1:0]  d_0,
    input  logic           we_0,
    input  logic           rd_0,
    output logic [DW-1:0]  spo_0,
    output logic           ready_0,
    input  logic           burst_en_1,
    input  logic [BLW-1:0] burst_length_1,
    input  logic [AW-1:0]  a_1,
    input  logic [DW-1:0]  d_1,
    input  logic           we_1,
    input  logic           rd_1,
    output logic [DW-1:0]  spo_1,
    output logic           ready_1,
    output logic           burst_en_mem,
    output logic [BLW-1:0] burst_length_mem,
    output logic [AW-1:0]  a_mem,
    output logic [DW-1:0]  d_mem,
    output logic           we_mem,
    output logic           rd_mem,
    input  logic [DW-1:0]  spo_mem,
    input  logic           ready_mem,
    output logic [1:0]     grant,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [BLW-1:0] r_cnt;
    logic [BLW-1:0] r_beats;
    logic [BLW-1:0] w_beats_sel;
    logic           w_req0;
    logic           w_req1;
    logic           w_sel1;
    logic           w_last;
`ifdef MEM_ARB_RR_EN
    logic           r_ptr;
`endif

    always_comb begin
        w_req0 = we_0 | rd_0;
        w_req1 = we_1 | rd_1;
`ifdef MEM_ARB_RR_EN
        // On contention the port that was not granted last wins.
        w_sel1 = w_req1 & (~w_req0 | ~r_ptr);
`else
        w_sel1 = w_req1 & ~w_req0;
`endif
        w_beats_sel = BLW'(1);
        if (w_sel1) begin
            if (burst_en_1 && (burst_length_1 != '0)) w_beats_sel = burst_length_1;
        end else begin
            if (burst_en_0 && (burst_length_0 != '0)) w_beats_sel = burst_length_0;
        end
        w_last = ((r_cnt + BLW'(1)) == r_beats);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req0 || w_req1) w_next = w_sel1 ? OWN1 : OWN0;
            OWN0,
            OWN1:    if (ready_mem && w_last) w_next = RELEASE;
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_beats <= '0;
`ifdef MEM_ARB_RR_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (w_req0 || w_req1)) begin
                r_beats <= w_beats_sel;
                r_cnt   <= '0;
`ifdef MEM_ARB_RR_EN
                r_ptr   <= w_sel1;
`endif
            end else if ((r_state == OWN0 || r_state == OWN1) && ready_mem) begin
                r_cnt <= w_last ? '0 : r_cnt + BLW'(1);
            end
        end
    end

    // Memory side follows the owner combinationally; controls are low outside OWNx.
    always_comb begin
        a_mem            = a_0;
        d_mem            = d_0;
        burst_length_mem = burst_length_0;
        burst_en_mem     = 1'b0;
        we_mem           = 1'b0;
        rd_mem           = 1'b0;
        ready_0          = 1'b0;
        ready_1          = 1'b0;
        grant            = 2'b00;
        case (r_state)
            OWN0: begin
                burst_en_mem = burst_en_0;
                we_mem       = we_0;
                rd_mem       = rd_0;
                ready_0      = ready_mem;
                grant        = 2'b01;
            end
            OWN1: begin
                a_mem            = a_1;
                d_mem            = d_1;
                burst_length_mem = burst_length_1;
                burst_en_mem     = burst_en_1;
                we_mem           = we_1;
                rd_mem           = rd_1;
                ready_1          = ready_mem;
                grant            = 2'b10;
            end
            default: ;
        endcase
    end

    assign spo_0 = spo_mem;
    assign spo_1 = spo_mem;
    assign busy  = |grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the test bench plays both masters and the memory controller.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BLW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           burst_en_0, burst_en_1, burst_en_mem;
    logic [BLW-1:0] burst_length_0, burst_length_1, burst_length_mem;
    logic [AW-1:0]  a_0, a_1, a_mem;
    logic [DW-1:0]  d_0, d_1, d_mem;
    logic           we_0, we_1, we_mem, rd_0, rd_1, rd_mem;
    logic [DW-1:0]  spo_0, spo_1, spo_mem;
    logic           ready_0, ready_1, ready_mem;
    logic [1:0]     grant;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;
    int tb_ptr = 0;
    int p, q;
    int exp_order [4];

    mem_arbiter #(.AW(AW), .DW(DW), .BLW(BLW)) dut (
        .clk(clk), .rst(rst),
        .burst_en_0(burst_en_0), .burst_length_0(burst_length_0), .a_0(a_0), .d_0(d_0),
        .we_0(we_0), .rd_0(rd_0), .spo_0(spo_0), .ready_0(ready_0),
        .burst_en_1(burst_en_1), .burst_length_1(burst_length_1), .a_1(a_1), .d_1(d_1),
        .we_1(we_1), .rd_1(rd_1), .spo_1(spo_1), .ready_1(ready_1),
        .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem), .a_mem(a_mem),
        .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem), .spo_mem(spo_mem),
        .ready_mem(ready_mem), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already set; predicts and checks the winner.
    task automatic grant_chk(output int port);
        logic q0, q1;
        int   e;
        q0 = we_0 | rd_0;
        q1 = we_1 | rd_1;
        if (q0 && q1) begin
`ifdef MEM_ARB_RR_EN
            e = (tb_ptr == 0) ? 1 : 0;
`else
            e = 0;
`endif
        end else begin
            e = q1 ? 1 : 0;
        end
        chk("idle_grant_pre", grant, 2'b00);
        chk("idle_ctrl_pre", {we_mem, rd_mem, burst_en_mem}, 3'b000);
        tick;
        chk("grant", grant, (e == 1) ? 2'b10 : 2'b01);
        chk("busy", busy, 1'b1);
        tb_ptr = e;
        port   = e;
    endtask

    task automatic beat(input int port, input int lat, input logic [31:0] data, input bit last);
        repeat (lat) tick;
        ready_mem = 1'b1;
        spo_mem   = data;
        #1;
        chk("ready_owner", (port == 1) ? ready_1 : ready_0, 1'b1);
        chk("ready_other", (port == 1) ? ready_0 : ready_1, 1'b0);
        chk("spo_owner", (port == 1) ? spo_1 : spo_0, data);
        tick;
        ready_mem = 1'b0;
        chk(last ? "grant_release" : "grant_held", grant,
            last ? 2'b00 : ((port == 1) ? 2'b10 : 2'b01));
    endtask

    task automatic release_chk(input int port, input bit drop);
        chk("rel_ctrl", {we_mem, rd_mem, burst_en_mem}, 3'b000);
        chk("rel_busy", busy, 1'b0);
        ready_mem = 1'b1;
        #1;
        chk("rel_ready_ignored", {ready_1, ready_0}, 2'b00);
        if (drop) begin
            if (port == 1) begin rd_1 = 1'b0; we_1 = 1'b0; burst_en_1 = 1'b0; end
            else           begin rd_0 = 1'b0; we_0 = 1'b0; burst_en_0 = 1'b0; end
        end
        tick;
        ready_mem = 1'b0;
        #1;
        chk("idle_after_rel", grant, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        {burst_en_0, burst_en_1, we_0, we_1, rd_0, rd_1, ready_mem} = '0;
        burst_length_0 = '0; burst_length_1 = '0;
        a_0 = '0; a_1 = '0; d_0 = '0; d_1 = '0; spo_mem = '0;
        tick; tick;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctrl", {we_mem, rd_mem, burst_en_mem}, 3'b000);
        rst = 1'b0;
        tick;

        // Single read on port 0, memory answers on the third owned cycle.
        rd_0 = 1'b1; a_0 = 32'h100;
        #1;
        chk("req_latency", rd_mem, 1'b0);
        grant_chk(p);
        chk("t1_port", p, 0);
        chk("t1_a_mem", a_mem, 32'h100);
        chk("t1_rd_mem", {we_mem, rd_mem}, 2'b01);
        beat(0, 2, 32'hDEADBEEF, 1'b1);
        release_chk(0, 1'b1);

        // Simultaneous rd_0 and we_1.
        rd_0 = 1'b1; a_0 = 32'h200;
        we_1 = 1'b1; a_1 = 32'h300; d_1 = 32'h12345678;
        grant_chk(p);
        beat(p, 1, 32'h0000_0A00, 1'b1);
        release_chk(p, 1'b1);
        grant_chk(q);
        chk("t2_second_port", q, 1 - p);
        if (q == 1) begin
            chk("t2_we_mem", {we_mem, rd_mem}, 2'b10);
            chk("t2_d_mem", d_mem, 32'h12345678);
            chk("t2_a_mem", a_mem, 32'h300);
        end
        beat(q, 0, 32'h0000_0A01, 1'b1);
        release_chk(q, 1'b1);

        // Port 1 four-beat burst with port 0 requesting during it.
        rd_1 = 1'b1; burst_en_1 = 1'b1; burst_length_1 = 8'd4; a_1 = 32'h400;
        grant_chk(p);
        chk("t3_port", p, 1);
        chk("t3_burst_mem", {burst_en_mem, burst_length_mem}, {1'b1, 8'd4});
        rd_0 = 1'b1; burst_length_1 = 8'd2;
        beat(1, 0, 32'hB000_0001, 1'b0);
        beat(1, 1, 32'hB000_0002, 1'b0);
        beat(1, 0, 32'hB000_0003, 1'b0);
        beat(1, 0, 32'hB000_0004, 1'b1);
        release_chk(1, 1'b1);
        grant_chk(p);
        chk("t3_port0_after", p, 0);
        beat(0, 0, 32'hC0DE_0000, 1'b1);
        release_chk(0, 1'b1);

        // Burst length 0 counts as one beat.
        rd_0 = 1'b1; burst_en_0 = 1'b1; burst_length_0 = 8'd0;
        grant_chk(p);
        beat(0, 1, 32'h0000_00B0, 1'b1);
        release_chk(0, 1'b1);

        // Reset in the middle of a port 1 burst.
        rd_1 = 1'b1; burst_en_1 = 1'b1; burst_length_1 = 8'd4;
        grant_chk(p);
        beat(1, 0, 32'h0000_0051, 1'b0);
        beat(1, 0, 32'h0000_0052, 1'b0);
        rst = 1'b1;
        tick;
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_ctrl", {we_mem, rd_mem}, 2'b00);
        rst = 1'b0; rd_1 = 1'b0; burst_en_1 = 1'b0; tb_ptr = 0;
        tick;
        rd_0 = 1'b1; a_0 = 32'h500;
        grant_chk(p);
        chk("t5_after_port", p, 0);
        chk("t5_after_a", a_mem, 32'h500);
        beat(0, 1, 32'h0000_0055, 1'b1);
        release_chk(0, 1'b1);

        // Both ports requesting continuously for four transactions.
        rst = 1'b1; tick; rst = 1'b0; tb_ptr = 0; tick;
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        rd_0 = 1'b1; rd_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            grant_chk(p);
            chk("t6_order", p, exp_order[i]);
            beat(p, 0, 32'h6000_0000 + i, 1'b1);
            release_chk(p, 1'b0);
        end
        rd_0 = 1'b0; rd_1 = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
